// File: rtl/fetch.sv
// Fetch stage: holds the fetch PC, issues single-outstanding reads
// to instruction memory and offers one registered instruction to decode.
module fetch #(
  parameter logic [31:0] RESET_PC = 32'h0,
  parameter logic [31:0] NOP      = 32'h8000_0000
) (
  input  logic        clock,
  input  logic        reset_n,
  input  logic        hold,
  input  logic        is_pc_changing,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  output logic [31:0] mem_address,
  output logic        mem_read,
  input  logic        mem_waitrequest,
  input  logic [31:0] mem_readdata,
  input  logic        mem_readdatavalid,
  output logic [31:0] instruction,
  output logic [31:0] pc
);

  localparam logic [1:0] S_REQUEST   = 2'd0;
  localparam logic [1:0] S_WAIT_DATA = 2'd1;
  localparam logic [1:0] S_DRAIN     = 2'd2;
  localparam logic [1:0] S_STOPPED   = 2'd3;

  logic [1:0]  state_q, state_d;
  logic        drain_stop_q, drain_stop_d;
  logic [31:0] fetch_pc_q, fetch_pc_d;
  logic [31:0] req_pc_q, req_pc_d;
  logic        slot_valid_q, slot_valid_d;
  logic [31:0] instr_q, instr_d;
  logic [31:0] pc_q, pc_d;
  logic        skid_valid_q, skid_valid_d;
  logic [31:0] skid_instr_q, skid_instr_d;
  logic [31:0] skid_pc_q, skid_pc_d;

  logic accept;
  logic resp;
  logic pending;
  logic free;
  logic flush;

  // Reset gates the request so memory sees nothing while the core is held.
  assign mem_read    = reset_n & (state_q == S_REQUEST) & ~skid_valid_q;
  assign mem_address = fetch_pc_q;
  assign instruction = instr_q;
  assign pc          = pc_q;

  assign accept  = mem_read & ~mem_waitrequest;
  assign resp    = mem_readdatavalid & (state_q == S_WAIT_DATA);
  assign free    = ~slot_valid_q | ~hold;
  assign flush   = is_pc_changing & ~hold;
  assign pending = accept
                 | (((state_q == S_WAIT_DATA) | (state_q == S_DRAIN))
                    & ~mem_readdatavalid);

  always_comb begin
    state_d      = state_q;
    drain_stop_d = drain_stop_q;
    fetch_pc_d   = fetch_pc_q;
    req_pc_d     = req_pc_q;
    slot_valid_d = slot_valid_q;
    instr_d      = instr_q;
    pc_d         = pc_q;
    skid_valid_d = skid_valid_q;
    skid_instr_d = skid_instr_q;
    skid_pc_d    = skid_pc_q;

    unique case (state_q)
      S_REQUEST: begin
        if (accept) begin
          state_d    = S_WAIT_DATA;
          fetch_pc_d = fetch_pc_q + 32'd1;
          req_pc_d   = fetch_pc_q;
        end
      end
      S_WAIT_DATA: begin
        if (mem_readdatavalid) state_d = S_REQUEST;
      end
      S_DRAIN: begin
        if (mem_readdatavalid)
          state_d = drain_stop_q ? S_STOPPED : S_REQUEST;
      end
      S_STOPPED: begin
        state_d = S_STOPPED;
      end
    endcase

    if (free) begin
      if (skid_valid_q) begin
        slot_valid_d = 1'b1;
        instr_d      = skid_instr_q;
        pc_d         = skid_pc_q;
        skid_valid_d = 1'b0;
      end else if (resp) begin
        slot_valid_d = 1'b1;
        instr_d      = mem_readdata;
        pc_d         = req_pc_q;
      end else begin
        slot_valid_d = 1'b0;
        instr_d      = NOP;
      end
    end

    if (resp && (!free || skid_valid_q)) begin
      skid_valid_d = 1'b1;
      skid_instr_d = mem_readdata;
      skid_pc_d    = req_pc_q;
    end

    if (flush) begin
      skid_valid_d = 1'b0;
      slot_valid_d = 1'b0;
      instr_d      = NOP;
      state_d      = pending ? S_DRAIN : S_STOPPED;
      drain_stop_d = 1'b1;
    end

    // Redirect wins over flush and over data returning this cycle.
    if (redirect_valid) begin
      fetch_pc_d   = redirect_pc;
      skid_valid_d = 1'b0;
      slot_valid_d = 1'b0;
      instr_d      = NOP;
      state_d      = pending ? S_DRAIN : S_REQUEST;
      drain_stop_d = 1'b0;
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q      <= S_REQUEST;
      drain_stop_q <= 1'b0;
      fetch_pc_q   <= RESET_PC;
      req_pc_q     <= RESET_PC;
      slot_valid_q <= 1'b0;
      instr_q      <= NOP;
      pc_q         <= RESET_PC;
      skid_valid_q <= 1'b0;
      skid_instr_q <= NOP;
      skid_pc_q    <= RESET_PC;
    end else begin
      state_q      <= state_d;
      drain_stop_q <= drain_stop_d;
      fetch_pc_q   <= fetch_pc_d;
      req_pc_q     <= req_pc_d;
      slot_valid_q <= slot_valid_d;
      instr_q      <= instr_d;
      pc_q         <= pc_d;
      skid_valid_q <= skid_valid_d;
      skid_instr_q <= skid_instr_d;
      skid_pc_q    <= skid_pc_d;
    end
  end

endmodule
